// File: rtl/mesh_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mesh_pkg
// Description : Shared mesh definitions: default packet width, position of
//               the VC/polarity bit and the packet container type.
// Revision    : 1.0 - initial release
// ============================================================================
package mesh_pkg;

    // Default packet width; the top bit is the VC/polarity bit.
    localparam int PACKET_WIDTH = 64;
    localparam int VC_BIT       = 63;

    // Default number of entries per link direction.
    localparam int LINK_DEPTH   = 2;

    typedef logic [PACKET_WIDTH-1:0] packet_t;

endpackage : mesh_pkg
`default_nettype wire

// File: rtl/mesh_link_fifo.sv
`default_nettype none
// ============================================================================
// Module      : mesh_link_fifo
// Description : One direction of the inter-row link. Small FIFO using the
//               mesh send/ready handshake on both sides.
//               Ports:
//                 clk, reset     clock, asynchronous active-high reset
//                 i_send/o_ready upstream handshake, i_data upstream packet
//                 o_send/i_ready downstream handshake, o_data head packet
//                 o_occupied     FIFO holds at least one packet
// Revision    : 1.0 - initial release
// ============================================================================
module mesh_link_fifo #(
    parameter int PACKET_WIDTH = mesh_pkg::PACKET_WIDTH,
    parameter int DEPTH        = mesh_pkg::LINK_DEPTH
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    i_send,
    output logic                    o_ready,
    input  logic [PACKET_WIDTH-1:0] i_data,
    output logic                    o_send,
    input  logic                    i_ready,
    output logic [PACKET_WIDTH-1:0] o_data,
    output logic                    o_occupied
);

    localparam int c_addr_w = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int c_cnt_w  = $clog2(DEPTH + 1);
    localparam logic [c_cnt_w-1:0]  c_depth   = c_cnt_w'(DEPTH);
    localparam logic [c_addr_w-1:0] c_ptr_one = c_addr_w'(1);
    localparam logic [c_cnt_w-1:0]  c_cnt_one = c_cnt_w'(1);

    logic [PACKET_WIDTH-1:0] r_mem [DEPTH];
    logic [c_addr_w-1:0]     r_rd_ptr;
    logic [c_addr_w-1:0]     r_wr_ptr;
    logic [c_cnt_w-1:0]      r_count;

    logic w_ready;
    logic w_not_empty;
    logic w_push;
    logic w_pop;

    // Ready depends only on registered occupancy, so the far-side ready
    // never reaches the near-side ready combinationally. A pop in the same
    // cycle does not free a slot for a simultaneous push when full.
    assign w_ready     = (r_count < c_depth);
    assign w_not_empty = (r_count != '0);
    assign w_push      = i_send & w_ready;
    assign w_pop       = w_not_empty & i_ready;

    // DEPTH is a power of two, so natural pointer overflow is modulo DEPTH;
    // occupancy alone distinguishes full from empty.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_one;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_one;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_cnt_one;
                2'b01:   r_count <= r_count - c_cnt_one;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage is deliberately not reset; empty-state masking of o_data keeps
    // stale contents invisible.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    assign o_ready    = w_ready;
    assign o_send     = w_pop;
    assign o_data     = w_not_empty ? r_mem[r_rd_ptr] : '0;
    assign o_occupied = w_not_empty;

endmodule : mesh_link_fifo
`default_nettype wire

// File: rtl/mesh_row_link_buffer.sv
`default_nettype none
// ============================================================================
// Module      : mesh_row_link_buffer
// Description : Registered elastic vertical link between the north-facing
//               ports of a mesh row and the south-facing ports of the row
//               above. Two independent FIFO directions.
//               Ports:
//                 clk, reset            clock, async active-high reset
//                 lo_si/lo_ri/lo_di     northbound in  (from lower router)
//                 up_so/up_ro/up_do     northbound out (to upper router)
//                 up_si/up_ri/up_di     southbound in  (from upper router)
//                 lo_so/lo_ro/lo_do     southbound out (to lower router)
//               Optional (macro LINK_STATS_EN):
//                 nb_pkt_cnt, sb_pkt_cnt      packets delivered per direction
//                 nb_stall_cnt, sb_stall_cnt  cycles held with ready low
// Revision    : 1.0 - initial release
// ============================================================================
module mesh_row_link_buffer #(
    parameter int PACKET_WIDTH = mesh_pkg::PACKET_WIDTH,
    parameter int DEPTH        = mesh_pkg::LINK_DEPTH
) (
    input  logic                    clk,
    input  logic                    reset,
    // northbound: lower router -> upper router
    input  logic                    lo_si,
    output logic                    lo_ri,
    input  logic [PACKET_WIDTH-1:0] lo_di,
    output logic                    up_so,
    input  logic                    up_ro,
    output logic [PACKET_WIDTH-1:0] up_do,
    // southbound: upper router -> lower router
    input  logic                    up_si,
    output logic                    up_ri,
    input  logic [PACKET_WIDTH-1:0] up_di,
    output logic                    lo_so,
    input  logic                    lo_ro,
`ifdef LINK_STATS_EN
    output logic [PACKET_WIDTH-1:0] lo_do,
    output logic [31:0]             nb_pkt_cnt,
    output logic [31:0]             sb_pkt_cnt,
    output logic [31:0]             nb_stall_cnt,
    output logic [31:0]             sb_stall_cnt
`else
    output logic [PACKET_WIDTH-1:0] lo_do
`endif
);

    logic w_nb_occupied;
    logic w_sb_occupied;

    mesh_link_fifo #(
        .PACKET_WIDTH (PACKET_WIDTH),
        .DEPTH        (DEPTH)
    ) u_nb_fifo (
        .clk        (clk),
        .reset      (reset),
        .i_send     (lo_si),
        .o_ready    (lo_ri),
        .i_data     (lo_di),
        .o_send     (up_so),
        .i_ready    (up_ro),
        .o_data     (up_do),
        .o_occupied (w_nb_occupied)
    );

    mesh_link_fifo #(
        .PACKET_WIDTH (PACKET_WIDTH),
        .DEPTH        (DEPTH)
    ) u_sb_fifo (
        .clk        (clk),
        .reset      (reset),
        .i_send     (up_si),
        .o_ready    (up_ri),
        .i_data     (up_di),
        .o_send     (lo_so),
        .i_ready    (lo_ro),
        .o_data     (lo_do),
        .o_occupied (w_sb_occupied)
    );

`ifdef LINK_STATS_EN
    logic [31:0] r_nb_pkt_cnt;
    logic [31:0] r_sb_pkt_cnt;
    logic [31:0] r_nb_stall_cnt;
    logic [31:0] r_sb_stall_cnt;

    // A pop is exactly a cycle where send-out is high; a stall is a cycle
    // with data held while the far side is not ready. Counters wrap.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_nb_pkt_cnt   <= '0;
            r_sb_pkt_cnt   <= '0;
            r_nb_stall_cnt <= '0;
            r_sb_stall_cnt <= '0;
        end else begin
            if (up_so)                   r_nb_pkt_cnt   <= r_nb_pkt_cnt + 32'd1;
            if (lo_so)                   r_sb_pkt_cnt   <= r_sb_pkt_cnt + 32'd1;
            if (w_nb_occupied && !up_ro) r_nb_stall_cnt <= r_nb_stall_cnt + 32'd1;
            if (w_sb_occupied && !lo_ro) r_sb_stall_cnt <= r_sb_stall_cnt + 32'd1;
        end
    end

    assign nb_pkt_cnt   = r_nb_pkt_cnt;
    assign sb_pkt_cnt   = r_sb_pkt_cnt;
    assign nb_stall_cnt = r_nb_stall_cnt;
    assign sb_stall_cnt = r_sb_stall_cnt;
`else
    // Occupancy is only consumed by the statistics counters.
    logic w_unused_occupied;
    assign w_unused_occupied = w_nb_occupied ^ w_sb_occupied;
`endif

endmodule : mesh_row_link_buffer
`default_nettype wire

// File: tb/tb_mesh_row_link_buffer.sv
`default_nettype none
// ============================================================================
// Module      : tb_mesh_row_link_buffer
// Description : Directed self-checking bench for mesh_row_link_buffer
//               (DEPTH = 2). Stats checks compile in with LINK_STATS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mesh_row_link_buffer;

    logic        clk = 1'b0;
    logic        reset;
    logic        lo_si, up_ro, up_si, lo_ro;
    logic [63:0] lo_di, up_di;
    logic        lo_ri, up_so, up_ri, lo_so;
    logic [63:0] up_do, lo_do;
`ifdef LINK_STATS_EN
    logic [31:0] nb_pkt_cnt, sb_pkt_cnt, nb_stall_cnt, sb_stall_cnt;
`endif

    int n_vec = 0;
    int n_err = 0;

    mesh_row_link_buffer #(
        .PACKET_WIDTH (64),
        .DEPTH        (2)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .lo_si        (lo_si),
        .lo_ri        (lo_ri),
        .lo_di        (lo_di),
        .up_so        (up_so),
        .up_ro        (up_ro),
        .up_do        (up_do),
        .up_si        (up_si),
        .up_ri        (up_ri),
        .up_di        (up_di),
        .lo_so        (lo_so),
        .lo_ro        (lo_ro),
`ifdef LINK_STATS_EN
        .lo_do        (lo_do),
        .nb_pkt_cnt   (nb_pkt_cnt),
        .sb_pkt_cnt   (sb_pkt_cnt),
        .nb_stall_cnt (nb_stall_cnt),
        .sb_stall_cnt (sb_stall_cnt)
`else
        .lo_do        (lo_do)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Return 1 ns after the rising edge; inputs are then driven and
    // outputs checked a further 1 ns later, well clear of the next edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        lo_si = 1'b0; up_si = 1'b0;
        up_ro = 1'b1; lo_ro = 1'b1;
        lo_di = '0;   up_di = '0;
        tick(); tick();
        #1;
        check("rst_lo_ri", lo_ri, 1);
        check("rst_up_ri", up_ri, 1);
        check("rst_up_so", up_so, 0);
        check("rst_lo_so", lo_so, 0);
        check("rst_up_do", up_do, 0);
        check("rst_lo_do", lo_do, 0);
        tick();
        reset = 1'b0;

        // ---- single northbound packet ----
        up_ro = 1'b1; lo_si = 1'b1; lo_di = 64'h8000_0000_0000_00A5;
        #1;
        check("single_pre_so", up_so, 0);
        tick();
        lo_si = 1'b0; lo_di = '0;
        #1;
        check("single_so", up_so, 1);
        check("single_do", up_do, 64'h8000_0000_0000_00A5);
        tick();
        #1;
        check("single_after_so", up_so, 0);
        check("single_after_ri", lo_ri, 1);
        check("single_after_do", up_do, 0);

        // ---- backpressure fill ----
        up_ro = 1'b0; lo_si = 1'b1; lo_di = 64'h11;
        tick();
        lo_di = 64'h22;
        #1;
        check("bp_one_ri", lo_ri, 1);
        check("bp_one_so", up_so, 0);
        check("bp_one_do", up_do, 64'h11);
        tick();
        lo_di = 64'h33;
        #1;
        check("bp_full_ri", lo_ri, 0);
        tick();
        lo_si = 1'b0; lo_di = '0;
        #1;
        check("bp_third_ri", lo_ri, 0);
        check("bp_third_do", up_do, 64'h11);
        up_ro = 1'b1;
        #1;
        check("bp_drain0_so", up_so, 1);
        check("bp_drain0_do", up_do, 64'h11);
        tick();
        #1;
        check("bp_drain1_so", up_so, 1);
        check("bp_drain1_do", up_do, 64'h22);
        check("bp_drain1_ri", lo_ri, 1);
        tick();
        #1;
        check("bp_empty_so", up_so, 0);
        check("bp_empty_ri", lo_ri, 1);

        // ---- streaming 1..16 ----
        for (int k = 0; k <= 16; k++) begin
            lo_si = (k < 16);
            lo_di = (k < 16) ? 64'(k + 1) : 64'h0;
            #1;
            check("stream_ri", lo_ri, 1);
            if (k > 0) begin
                check("stream_so", up_so, 1);
                check("stream_do", up_do, 64'(k));
            end
            tick();
        end
        lo_si = 1'b0;
        #1;
        check("stream_end_so", up_so, 0);

        // ---- bidirectional independence ----
        up_ro = 1'b0; lo_si = 1'b1; lo_di = 64'hC1;
        tick();
        lo_di = 64'hC2;
        tick();
        lo_si = 1'b0; lo_di = '0;
        lo_ro = 1'b1;
        for (int k = 0; k <= 8; k++) begin
            up_si = (k < 8);
            up_di = (k < 8) ? 64'hB0 + 64'(k) : 64'h0;
            #1;
            check("bidir_up_ri", up_ri, 1);
            check("bidir_nb_ri", lo_ri, 0);
            check("bidir_nb_so", up_so, 0);
            if (k > 0) begin
                check("bidir_sb_so", lo_so, 1);
                check("bidir_sb_do", lo_do, 64'hB0 + 64'(k - 1));
            end
            tick();
        end
        up_si = 1'b0; up_di = '0;
        #1;
        check("bidir_sb_end", lo_so, 0);
        check("bidir_nb_keep", up_do, 64'hC1);
        up_ro = 1'b1;
        #1;
        check("bidir_nb_so1", up_so, 1);
        tick();
        up_ro = 1'b0; lo_si = 1'b1; lo_di = 64'hC3;
        #1;
        check("bidir_nb_do2", up_do, 64'hC2);
        check("bidir_nb_ri2", lo_ri, 1);
        tick();
        lo_si = 1'b0; lo_di = '0;
        #1;
        check("held2_ri", lo_ri, 0);
        check("held2_do", up_do, 64'hC2);

        // ---- asynchronous reset with 2 entries held ----
        up_ro = 1'b1;
        #1;
        check("held2_so", up_so, 1);
        reset = 1'b1;
        #1;
        check("arst_lo_ri", lo_ri, 1);
        check("arst_up_so", up_so, 0);
        check("arst_up_do", up_do, 0);
        tick(); tick();
        reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            check("post_rst_so", up_so, 0);
            check("post_rst_do", up_do, 0);
            tick();
        end

`ifdef LINK_STATS_EN
        // ---- statistics: 5 northbound pops, 3 stall cycles ----
        #1;
        check("stat_rst_nb_pkt", nb_pkt_cnt, 0);
        check("stat_rst_nb_stall", nb_stall_cnt, 0);
        up_ro = 1'b0; lo_si = 1'b1; lo_di = 64'hD1;
        tick();                         // push D1
        lo_di = 64'hD2;
        tick();                         // push D2, stall 1
        lo_si = 1'b0; lo_di = '0;
        tick();                         // stall 2
        tick();                         // stall 3
        up_ro = 1'b1;
        tick();                         // pop 1
        tick();                         // pop 2
        lo_si = 1'b1; lo_di = 64'hD3;
        tick();                         // push D3
        lo_di = 64'hD4;
        tick();                         // push D4, pop 3
        lo_di = 64'hD5;
        tick();                         // push D5, pop 4
        lo_si = 1'b0; lo_di = '0;
        tick();                         // pop 5
        #1;
        check("stat_nb_pkt", nb_pkt_cnt, 5);
        check("stat_nb_stall", nb_stall_cnt, 3);
        check("stat_sb_pkt", sb_pkt_cnt, 0);
        check("stat_sb_stall", sb_stall_cnt, 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_mesh_row_link_buffer
`default_nettype wire
